sram_arb_ctrl: RTL and testbench
================================

Name: sram_arb_ctrl

Overview:
Parametrised controller for the asynchronous 16-bit SRAM on the board, replacing the single-client fixed-timing controller.
- Serves NUM_CH clients through per-channel valid/ready request ports, with round-robin arbitration.
- Supports programmable read, write and turnaround cycle counts, byte-lane writes, and a masking option for unusable data bits.
- Sits between the pixel/graphics clients and the top-level tristate SRAM pads.

Parameters:
- ADDR_W, 18: SRAM word address width.
- DATA_W, 16: data width; must be a multiple of 8.
- NUM_CH, 2: number of client channels, 1..8.
- WR_CYCLES, 1: cycles WE_n is held low; must be ≥1.
- RD_CYCLES, 1: cycles OE_n is held low before data is sampled; must be ≥1.
- TURN_CYCLES, 1: idle cycles (CS_n high) after each access; may be 0.
- BAD_BITS, 16'h2000: read-data bits forced to 0; DATA_W wide.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept, combinational.
- req_write  in  NUM_CH  1=write, 0=read.
- req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i in slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  packed write data.
- req_be  in  NUM_CH*DATA_W/8  packed byte enables, active high.
- rd_valid  out  NUM_CH  one-cycle read-return pulse, one bit per channel.
- rd_data  out  DATA_W  read data, shared by all channels; valid when any rd_valid bit is high.
- busy  out  1  high whenever state != IDLE.
- address_pins  out  ADDR_W  SRAM address.
- data_pins_in  in  DATA_W  SRAM data from the pads.
- data_pins_out  out  DATA_W  SRAM data to the pads.
- data_pins_out_en  out  1  pad output enable.
- OE_n  out  1  SRAM output enable, active low.
- WE_n  out  1  SRAM write enable, active low.
- CS_n  out  1  SRAM chip select, active low.
- BE_n  out  DATA_W/8  SRAM byte lanes (UB_n/LB_n), active low.

Behaviour:
- Reset state: OE_n, WE_n, CS_n and BE_n all 1; data_pins_out_en 0; rd_valid 0; rd_data 0; address_pins 0; data_pins_out 0; busy 0; arbitration pointer 0; state IDLE.
- Reset mid-access: strobes go inactive at the next edge; no rd_valid is issued for the aborted access.
- All pin outputs are registered.
- States: IDLE, SETUP, WRITE, WR_HOLD, READ, TURN.
- IDLE arbitration:
  - Grant the first valid channel searching upward from (last_grant+1) mod NUM_CH.
  - req_ready[g] = (state==IDLE) & grant[g]; at most one bit is high.
  - Acceptance = valid & ready. On acceptance, latch addr, wdata, be, write and channel, and go to SETUP.
- SETUP (1 cycle): drive address; CS_n=0; BE_n=~be for writes, all 0 for reads.
  - Write: data_pins_out_en=1, next state WRITE.
  - Read: OE_n=0, next state READ.
- WRITE: WE_n=0 for WR_CYCLES cycles, then WR_HOLD.
- WR_HOLD (1 cycle): WE_n=1; data is still driven and CS_n is still 0 to give data hold time.
- READ: OE_n=0 for RD_CYCLES cycles.
  - On the last READ cycle's edge: rd_data <= data_pins_in & ~BAD_BITS.
  - rd_valid[ch] pulses in the following cycle.
- Exit from WR_HOLD or the last READ cycle: strobes inactive, data_pins_out_en=0, then TURN for TURN_CYCLES cycles, then IDLE. If TURN_CYCLES=0, go directly to IDLE.
- Read latency: acceptance at cycle 0 → rd_valid at cycle 2+RD_CYCLES.
- Write occupancy: 3+WR_CYCLES+TURN_CYCLES cycles from acceptance to the next possible acceptance.
- Invariants:
  - WE_n and OE_n are never low simultaneously.
  - data_pins_out_en is never high while OE_n is low.
  - CS_n is high in IDLE and TURN.
- Request inputs are ignored outside acceptance; clients hold valid and payload until ready.
- If a client drops valid before acceptance, nothing is recorded.

Test Plan:
- Reset, then a single ch0 write of 0xA5C3 to 0x00010 with be=11, WR_CYCLES=1: WE_n low exactly 1 cycle; BE_n=00; data_pins_out_en high for 3 cycles (SETUP, WRITE, WR_HOLD); ch0 ready again 5 cycles after acceptance.
- Ch1 read of 0x3FFFF with pads returning 0xFFFF and RD_CYCLES=2: rd_valid[1] 4 cycles after acceptance; rd_data=0xDFFF (bit 13 masked); rd_valid[0] stays 0.
- Byte write with be=01 to address 0x00005: BE_n=10 during SETUP, WRITE and WR_HOLD; BE_n=11 otherwise.
- Both channels hold valid continuously for 6 transactions: grants alternate 0,1,0,1,0,1; req_ready never high on both bits at once; no channel waits more than one transaction.
- Assert reset during a READ cycle: next cycle CS_n=OE_n=1; no rd_valid pulse appears; the first grant after reset goes to ch0.
- Randomised traffic with an SRAM model, 1000 operations: every read returns the last written masked data; the WE_n/OE_n and out_en/OE_n invariants are never violated.

Source files
------------

// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter and timing sequencer for the board's asynchronous SRAM.
// Every pin is a flop loaded from next-state values, so strobes line up with the state register.
module sram_arb_ctrl #(
   parameter int                ADDR_W      = 18,
   parameter int                DATA_W      = 16,
   parameter int                NUM_CH      = 2,
   parameter int                WR_CYCLES   = 1,
   parameter int                RD_CYCLES   = 1,
   parameter int                TURN_CYCLES = 1,
   parameter logic [DATA_W-1:0] BAD_BITS    = DATA_W'(16'h2000)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          req_valid,
   output logic [NUM_CH-1:0]          req_ready,
   input  logic [NUM_CH-1:0]          req_write,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
   input  logic [NUM_CH*DATA_W/8-1:0] req_be,
   output logic [NUM_CH-1:0]          rd_valid,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       busy,
   output logic [ADDR_W-1:0]          address_pins,
   input  logic [DATA_W-1:0]          data_pins_in,
   output logic [DATA_W-1:0]          data_pins_out,
   output logic                       data_pins_out_en,
   output logic                       OE_n,
   output logic                       WE_n,
   output logic                       CS_n,
   output logic [DATA_W/8-1:0]        BE_n
);
   localparam int BE_W      = DATA_W / 8;
   localparam int PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int MAX_WR_RD = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
   localparam int MAX_CYC   = (MAX_WR_RD > TURN_CYCLES) ? MAX_WR_RD : TURN_CYCLES;
   localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, WRITE, WR_HOLD, READ, TURN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  ch_q, ch_d;
   logic [PTR_W-1:0]  gidx, cand;
   logic              found;
   logic [NUM_CH-1:0] grant;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              wr_q, wr_d;
   logic [NUM_CH-1:0] rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] address_pins_q, address_pins_d;
   logic [DATA_W-1:0] data_pins_out_q, data_pins_out_d;
   logic              data_pins_out_en_q, data_pins_out_en_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              cs_n_q, cs_n_d;
   logic [BE_W-1:0]   be_n_q, be_n_d;

   // ptr_q holds the highest-priority channel, i.e. one past the last grant.
   always_comb begin
      grant = '0;
      gidx  = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % NUM_CH);
         if (!found && req_valid[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            found       = 1'b1;
         end
      end
   end

   assign req_ready = (state_q == IDLE) ? grant : '0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      ch_d       = ch_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      wr_d       = wr_q;
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      case (state_q)
         IDLE: begin
            if (|(req_valid & req_ready)) begin
               state_d = SETUP;
               ch_d    = gidx;
               ptr_d   = PTR_W'((int'(gidx) + 1) % NUM_CH);
               addr_d  = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
               wdata_d = req_wdata[int'(gidx)*DATA_W +: DATA_W];
               be_d    = req_be[int'(gidx)*BE_W +: BE_W];
               wr_d    = req_write[gidx];
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = wr_q ? WRITE : READ;
         end
         WRITE: begin
            if (cnt_q == CNT_W'(WR_CYCLES - 1)) state_d = WR_HOLD;
            else                                cnt_d   = cnt_q + 1'b1;
         end
         WR_HOLD: begin
            cnt_d   = '0;
            state_d = (TURN_CYCLES > 0) ? TURN : IDLE;
         end
         READ: begin
            if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
               rd_data_d        = data_pins_in & ~BAD_BITS;
               rd_valid_d[ch_q] = 1'b1;
               cnt_d            = '0;
               state_d          = (TURN_CYCLES > 0) ? TURN : IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TURN: begin
            if (cnt_q == CNT_W'(TURN_CYCLES - 1)) state_d = IDLE;
            else                                  cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Pins follow state_d so they change on the same edge as the state.
      cs_n_d             = 1'b1;
      oe_n_d             = 1'b1;
      we_n_d             = 1'b1;
      be_n_d             = '1;
      data_pins_out_en_d = 1'b0;
      address_pins_d     = address_pins_q;
      data_pins_out_d    = data_pins_out_q;
      if (state_d inside {SETUP, WRITE, WR_HOLD, READ}) begin
         cs_n_d         = 1'b0;
         address_pins_d = addr_d;
         be_n_d         = wr_d ? ~be_d : '0;
      end
      if (wr_d && (state_d inside {SETUP, WRITE, WR_HOLD})) begin
         data_pins_out_en_d = 1'b1;
         data_pins_out_d    = wdata_d;
      end
      if (state_d == WRITE) we_n_d = 1'b0;
      if ((state_d == READ) || (state_d == SETUP && !wr_d)) oe_n_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         ptr_q              <= '0;
         ch_q               <= '0;
         addr_q             <= '0;
         wdata_q            <= '0;
         be_q               <= '0;
         wr_q               <= 1'b0;
         rd_valid_q         <= '0;
         rd_data_q          <= '0;
         address_pins_q     <= '0;
         data_pins_out_q    <= '0;
         data_pins_out_en_q <= 1'b0;
         oe_n_q             <= 1'b1;
         we_n_q             <= 1'b1;
         cs_n_q             <= 1'b1;
         be_n_q             <= '1;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         ptr_q              <= ptr_d;
         ch_q               <= ch_d;
         addr_q             <= addr_d;
         wdata_q            <= wdata_d;
         be_q               <= be_d;
         wr_q               <= wr_d;
         rd_valid_q         <= rd_valid_d;
         rd_data_q          <= rd_data_d;
         address_pins_q     <= address_pins_d;
         data_pins_out_q    <= data_pins_out_d;
         data_pins_out_en_q <= data_pins_out_en_d;
         oe_n_q             <= oe_n_d;
         we_n_q             <= we_n_d;
         cs_n_q             <= cs_n_d;
         be_n_q             <= be_n_d;
      end
   end

   assign busy             = (state_q != IDLE);
   assign rd_valid         = rd_valid_q;
   assign rd_data          = rd_data_q;
   assign address_pins     = address_pins_q;
   assign data_pins_out    = data_pins_out_q;
   assign data_pins_out_en = data_pins_out_en_q;
   assign OE_n             = oe_n_q;
   assign WE_n             = we_n_q;
   assign CS_n             = cs_n_q;
   assign BE_n             = be_n_q;
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed and random checks of sram_arb_ctrl against a behavioural SRAM on the pins.
module tb_sram_arb_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready, req_write, rd_valid;
   logic [35:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [15:0] rd_data, data_pins_in, data_pins_out;
   logic        busy, data_pins_out_en, OE_n, WE_n, CS_n;
   logic [17:0] address_pins;
   logic [1:0]  BE_n;

   int n_cmp = 0;
   int n_fail = 0;

   logic [15:0] mem [0:262143];
   logic [15:0] ref_mem [0:15];

   sram_arb_ctrl #(
      .ADDR_W(18), .DATA_W(16), .NUM_CH(2), .WR_CYCLES(1), .RD_CYCLES(2),
      .TURN_CYCLES(1), .BAD_BITS(16'h2000)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
      .address_pins(address_pins), .data_pins_in(data_pins_in),
      .data_pins_out(data_pins_out), .data_pins_out_en(data_pins_out_en),
      .OE_n(OE_n), .WE_n(WE_n), .CS_n(CS_n), .BE_n(BE_n)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: byte-lane writes while WE_n is low, combinational reads while OE_n is low.
   always @(posedge clk) begin
      if (!CS_n && !WE_n) begin
         if (!BE_n[0]) mem[address_pins][7:0]  <= data_pins_out[7:0];
         if (!BE_n[1]) mem[address_pins][15:8] <= data_pins_out[15:8];
      end
   end
   assign data_pins_in = (!CS_n && !OE_n) ? mem[address_pins] : 16'h0000;

   task automatic set_req(input logic ch, input logic wr, input logic [17:0] a,
                          input logic [15:0] d, input logic [1:0] be);
      req_valid[ch]          = 1'b1;
      req_write[ch]          = wr;
      req_addr[ch*18 +: 18]  = a;
      req_wdata[ch*16 +: 16] = d;
      req_be[ch*2 +: 2]      = be;
   endtask

   task automatic do_write(input logic ch, input logic [17:0] a, input logic [15:0] d,
                           input logic [1:0] be);
      int t;
      req_valid = '0;
      set_req(ch, 1'b1, a, d, be);
      #1;
      t = 0;
      while (!req_ready[ch] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_cmp++; n_fail++;
         $display("FAIL do_write_ready_timeout: ch%0d never ready, required ready within 50 cycles", ch);
      end
      @(negedge clk);
      req_valid = '0;
      t = 0;
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_cmp++; n_fail++;
         $display("FAIL do_write_idle_timeout: busy=%b, required 0 within 50 cycles", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({OE_n, WE_n, CS_n} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes: got %b required 111", {OE_n, WE_n, CS_n}); end
      n_cmp++; if (BE_n !== 2'b11) begin n_fail++; $display("FAIL reset_be_n: got %b required 11", BE_n); end
      n_cmp++; if (data_pins_out_en !== 1'b0) begin n_fail++; $display("FAIL reset_out_en: got %b required 0", data_pins_out_en); end
      n_cmp++; if (rd_valid !== 2'b00 || rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd: got %b/%h required 00/0000", rd_valid, rd_data); end
      n_cmp++; if (address_pins !== 18'h0 || data_pins_out !== 16'h0) begin n_fail++; $display("FAIL reset_pins: got %h/%h required 0/0", address_pins, data_pins_out); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      reset = 1'b0;
   endtask

   task automatic test_single_write();
      int we_low = 0;
      int oen_hi = 0;
      set_req(1'b0, 1'b1, 18'h00010, 16'hA5C3, 2'b11);
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready_c0: got %b required 01", req_ready); end
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         we_low += (WE_n == 1'b0) ? 1 : 0;
         oen_hi += (data_pins_out_en == 1'b1) ? 1 : 0;
         n_cmp++; if (WE_n !== ((c == 2) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL wr_we_n_c%0d: got %b", c, WE_n); end
         n_cmp++; if (data_pins_out_en !== ((c <= 3) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL wr_out_en_c%0d: got %b", c, data_pins_out_en); end
         n_cmp++; if (req_ready !== ((c == 5) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL wr_ready_c%0d: got %b", c, req_ready); end
         if (c == 1) begin
            n_cmp++; if (CS_n !== 1'b0 || BE_n !== 2'b00) begin n_fail++; $display("FAIL wr_setup_cs_be: got %b/%b required 0/00", CS_n, BE_n); end
            n_cmp++; if (address_pins !== 18'h00010 || data_pins_out !== 16'hA5C3) begin n_fail++; $display("FAIL wr_setup_addr_data: got %h/%h required 00010/a5c3", address_pins, data_pins_out); end
         end
         if (c == 5) req_valid = '0;
      end
      n_cmp++; if (we_low != 1 || oen_hi != 3) begin n_fail++; $display("FAIL wr_pulse_counts: got we=%0d oe=%0d required 1/3", we_low, oen_hi); end
      n_cmp++; if (mem[18'h00010] !== 16'hA5C3) begin n_fail++; $display("FAIL wr_sram_content: got %h required a5c3", mem[18'h00010]); end
   endtask

   task automatic test_read();
      do_write(1'b1, 18'h3FFFF, 16'hFFFF, 2'b11);
      set_req(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00);
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rd_ready_c0: got %b required 10", req_ready); end
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         n_cmp++; if (rd_valid !== ((c == 4) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL rd_valid_c%0d: got %b", c, rd_valid); end
         if (c == 1) begin
            n_cmp++; if (OE_n !== 1'b0 || CS_n !== 1'b0 || BE_n !== 2'b00 || data_pins_out_en !== 1'b0) begin n_fail++; $display("FAIL rd_setup_strobes: got oe=%b cs=%b be=%b en=%b required 0/0/00/0", OE_n, CS_n, BE_n, data_pins_out_en); end
            n_cmp++; if (address_pins !== 18'h3FFFF) begin n_fail++; $display("FAIL rd_setup_addr: got %h required 3ffff", address_pins); end
            req_valid = '0;
         end
         if (c == 4) begin
            n_cmp++; if (rd_data !== 16'hDFFF) begin n_fail++; $display("FAIL rd_masked_data: got %h required dfff", rd_data); end
         end
      end
   endtask

   task automatic test_byte_write();
      do_write(1'b0, 18'h00005, 16'hFFFF, 2'b11);
      set_req(1'b0, 1'b1, 18'h00005, 16'h1234, 2'b01);
      #1;
      n_cmp++; if (BE_n !== 2'b11 || req_ready !== 2'b01) begin n_fail++; $display("FAIL bw_c0: got be_n=%b ready=%b required 11/01", BE_n, req_ready); end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = '0;
         n_cmp++; if (BE_n !== ((c <= 3) ? 2'b10 : 2'b11)) begin n_fail++; $display("FAIL bw_be_n_c%0d: got %b", c, BE_n); end
      end
      n_cmp++; if (mem[18'h00005] !== 16'hFF34) begin n_fail++; $display("FAIL bw_sram_content: got %h required ff34", mem[18'h00005]); end
   endtask

   task automatic test_back_to_back();
      int gch [0:5];
      int gcy [0:5];
      int ng = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      set_req(1'b0, 1'b1, 18'h00100, 16'h1111, 2'b11);
      set_req(1'b1, 1'b1, 18'h00101, 16'h2222, 2'b11);
      #1;
      for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
         n_cmp++; if (req_ready === 2'b11) begin n_fail++; $display("FAIL b2b_ready_onehot: got %b at cycle %0d", req_ready, cyc); end
         if (req_ready != 2'b00) begin
            gch[ng] = req_ready[1] ? 1 : 0;
            gcy[ng] = cyc;
            ng++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      n_cmp++; if (ng != 6) begin n_fail++; $display("FAIL b2b_grant_count: got %0d required 6", ng); end
      for (int i = 0; i < ng; i++) begin
         n_cmp++; if (gch[i] != i % 2) begin n_fail++; $display("FAIL b2b_grant_%0d: got ch%0d required ch%0d", i, gch[i], i % 2); end
         if (i > 0) begin
            n_cmp++; if (gcy[i] - gcy[i-1] != 5) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d required 5", i, gcy[i] - gcy[i-1]); end
         end
      end
      repeat (6) @(negedge clk);
      n_cmp++; if (mem[18'h00100] !== 16'h1111 || mem[18'h00101] !== 16'h2222) begin n_fail++; $display("FAIL b2b_sram_content: got %h/%h required 1111/2222", mem[18'h00100], mem[18'h00101]); end
   endtask

   task automatic test_reset_mid_read();
      set_req(1'b1, 1'b0, 18'h00101, 16'h0000, 2'b00);
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rst_rd_ready: got %b required 10", req_ready); end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      n_cmp++; if (OE_n !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_rd_in_read: got oe=%b busy=%b required 0/1", OE_n, busy); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (CS_n !== 1'b1 || OE_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_rd_strobes: got cs=%b oe=%b busy=%b required 1/1/0", CS_n, OE_n, busy); end
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_cmp++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rd_no_valid_%0d: got %b required 00", c, rd_valid); end
         @(negedge clk);
      end
      set_req(1'b0, 1'b0, 18'h00100, 16'h0000, 2'b00);
      set_req(1'b1, 1'b0, 18'h00101, 16'h0000, 2'b00);
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b required 01", req_ready); end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic        ch, wr, acc, done;
      logic [3:0]  a;
      logic [15:0] d, exp_d;
      logic [1:0]  be;
      for (int i = 0; i < 16; i++) begin
         d = 16'($urandom);
         do_write(1'b0, 18'h00200 + 18'(i), d, 2'b11);
         ref_mem[i] = d;
      end
      for (int op = 0; op < 1000; op++) begin
         ch = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = 4'($urandom_range(0, 15));
         d  = 16'($urandom);
         be = 2'($urandom_range(0, 3));
         exp_d = 16'h0;
         req_valid = '0;
         set_req(ch, wr, 18'h00200 + 18'(a), d, be);
         #1;
         acc = 1'b0;
         done = 1'b0;
         for (int t = 0; t < 40 && !done; t++) begin
            n_cmp++; if (!WE_n && !OE_n) begin n_fail++; $display("FAIL rnd_we_oe_overlap: op %0d we=%b oe=%b", op, WE_n, OE_n); end
            n_cmp++; if (data_pins_out_en && !OE_n) begin n_fail++; $display("FAIL rnd_out_en_oe: op %0d en=%b oe=%b", op, data_pins_out_en, OE_n); end
            if (acc) begin
               req_valid = '0;
               if (wr) begin
                  done = 1'b1;
               end else if (rd_valid != 2'b00) begin
                  n_cmp++; if (rd_valid !== (ch ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rnd_rd_valid: op %0d got %b for ch%0d", op, rd_valid, ch); end
                  n_cmp++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL rnd_rd_data: op %0d addr %h got %h required %h", op, a, rd_data, exp_d); end
                  done = 1'b1;
               end
            end else if (req_ready[ch]) begin
               acc = 1'b1;
               if (wr) begin
                  if (be[0]) ref_mem[a][7:0]  = d[7:0];
                  if (be[1]) ref_mem[a][15:8] = d[15:8];
               end else begin
                  exp_d = ref_mem[a] & ~16'h2000;
               end
            end
            @(negedge clk);
         end
         if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL rnd_timeout: op %0d not completed, required completion within 40 cycles", op);
            req_valid = '0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_byte_write();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
